// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780-style 8-bit LCD bus: performs RW=1 status or data
// reads, with an optional hardware busy-flag poll loop bounded by POLL_MAX reads.
module lcd_bus_reader #(
    parameter int unsigned T_AS     = 3,
    parameter int unsigned T_EH     = 25,
    parameter int unsigned T_EL     = 25,
    parameter int unsigned POLL_MAX = 1000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       req,
    input  logic       rs_sel,
    input  logic       poll,
    output logic       ready,
    output logic       done,
    output logic [7:0] dado,
    output logic       busy_flag,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_data_oe
);

    localparam int unsigned T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                                  : ((T_EH > T_EL) ? T_EH : T_EL);
    localparam int unsigned TW = $clog2(T_MAX + 1);
    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] EHIGH = 3'd2;
    localparam logic [2:0] ELOW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_next;
    logic [TW-1:0] phase_len_m1;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_next;
    logic          rs_lat;
    logic          poll_lat;
    logic [7:0]    sample;
    logic          phase_last;
    logic          retry;
    logic          accept;
    logic          sample_en;
    logic          finish;
    logic          finish_to;
    logic          active;

    always_comb begin
        case (state)
            SETUP:   phase_len_m1 = TW'(T_AS - 1);
            EHIGH:   phase_len_m1 = TW'(T_EH - 1);
            default: phase_len_m1 = TW'(T_EL - 1);
        endcase
    end

    assign phase_last = (tcnt == phase_len_m1);

    // Another status read is wanted only while polling and the controller reports busy.
    assign retry = poll_lat && !rs_lat && sample[7];

    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        pcnt_next  = pcnt;
        accept     = 1'b0;
        sample_en  = 1'b0;
        finish     = 1'b0;
        finish_to  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                    tcnt_next  = '0;
                    pcnt_next  = '0;
                end
            end
            SETUP: begin
                if (phase_last) begin
                    state_next = EHIGH;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            EHIGH: begin
                if (phase_last) begin
                    sample_en  = 1'b1;
                    state_next = ELOW;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            ELOW: begin
                if (phase_last) begin
                    tcnt_next = '0;
                    // pcnt counts reads already finished before the current one
                    if (retry && (pcnt < PW'(POLL_MAX - 1))) begin
                        state_next = SETUP;
                        pcnt_next  = pcnt + PW'(1);
                    end else begin
                        state_next = DONE;
                        finish     = 1'b1;
                        finish_to  = retry;
                    end
                end else begin
                    tcnt_next = tcnt + TW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                tcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            pcnt      <= '0;
            rs_lat    <= 1'b0;
            poll_lat  <= 1'b0;
            sample    <= 8'h00;
            dado      <= 8'h00;
            busy_flag <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            pcnt  <= pcnt_next;
            if (accept) begin
                rs_lat   <= rs_sel;
                poll_lat <= poll;
                timeout  <= 1'b0;
            end
            // Bus has been stable for most of the E-high window; no synchronizer needed.
            if (sample_en) begin
                sample <= lcd_data_in;
            end
            if (finish) begin
                dado      <= sample;
                busy_flag <= !rs_lat && sample[7];
                timeout   <= finish_to;
            end
        end
    end

    // Bus controls decode straight from state so reset drops E without a clock edge.
    assign active      = (state == SETUP) || (state == EHIGH) || (state == ELOW);
    assign ready       = (state == IDLE);
    assign done        = (state == DONE);
    assign lcd_en      = (state == EHIGH);
    assign lcd_rw      = active;
    assign lcd_rs      = active && rs_lat;
    assign lcd_data_oe = !active;

endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side engine for the HD44780-style 8-bit LCD bus: RS, RW, E and an 8-bit data bus.
- The existing LCD path only writes (RW held low). This block performs RW=1 read cycles and returns the result to the processor side:
  - status reads: busy flag BF plus address counter;
  - data RAM reads.
- It also offers a hardware busy-poll mode, so writes no longer need worst-case delays.
- Sits beside the LCD write conduit. A top-level mux hands RS/RW/E/oe to this block whenever ready=0.

Parameters:
T_AS, 3, RS/RW setup cycles before E rises (60 ns at 50 MHz); legal range >=1
T_EH, 25, E-high cycles (500 ns); data sampled on the last E-high cycle; legal range >=2
T_EL, 25, E-low recovery cycles after E falls, RW still 1; legal range >=1
POLL_MAX, 1000, maximum status reads in one poll request before timeout; legal range >=1

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  asynchronous active-low reset
req  input  1  start a read; accepted only while ready=1
rs_sel  input  1  0=status read (BF/AC), 1=data RAM read; latched on accept
poll  input  1  1 with rs_sel=0: repeat status reads until BF=0 or timeout; latched on accept
ready  output  1  idle, can accept req
done  output  1  one-cycle pulse; result outputs valid from this cycle
dado  output  8  last sampled byte; held until next done
busy_flag  output  1  dado[7] of last status read; 0 after data reads
timeout  output  1  set with done when poll limit reached; cleared on next accept
lcd_rs  output  1  LCD RS
lcd_rw  output  1  LCD RW
lcd_en  output  1  LCD E
lcd_data_in  input  8  LCD data bus pad input
lcd_data_oe  output  1  0 while this block owns the bus for reading (pad tristated)

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state IDLE, ready=1, done=0;
  - dado=8'h00, busy_flag=0, timeout=0;
  - lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data_oe=1.
  - E drops the same instant reset asserts; no recovery cycles are owed.
- States: IDLE, SETUP, EHIGH, ELOW, DONE.
- IDLE:
  - ready=1, lcd_rw=0, lcd_en=0, lcd_data_oe=1.
  - req=1 at edge k: latch rs_sel and poll, clear timeout and poll counter, go to SETUP.
- SETUP: T_AS cycles. lcd_rs=latched rs_sel, lcd_rw=1, lcd_data_oe=0, lcd_en=0, ready=0.
- EHIGH: T_EH cycles, lcd_en=1. On the last EHIGH cycle, lcd_data_in is registered into a sample register. No synchronizer: data has been stable for more than 100 ns by then.
- ELOW: T_EL cycles, lcd_en=0, RS/RW/oe unchanged. At its last cycle:
  - Repeat read (back to SETUP) when: poll latched, rs latched=0, sample[7]=1, and reads done < POLL_MAX. Counter increments.
  - Timeout (to DONE with timeout=1) when the same conditions hold but reads done = POLL_MAX.
  - Otherwise go to DONE.
- DONE: one cycle.
  - done=1; dado=sample; busy_flag=sample[7] if rs=0, else 0.
  - lcd_rw=0, lcd_data_oe=1, ready=0. Next cycle IDLE.
- Latency:
  - Single read: done at cycle k+T_AS+T_EH+T_EL+1 (54 with defaults).
  - Each extra poll read adds T_AS+T_EH+T_EL cycles.
- Back-to-back: req held high is re-accepted in the IDLE cycle after DONE. Minimum spacing between done pulses is T_AS+T_EH+T_EL+2.
- req while ready=0 is ignored, not queued. rs_sel/poll changes after accept have no effect.
- poll=1 with rs_sel=1 performs exactly one data read.
- Counters are sized to clog2 of the largest parameter. Counters and the poll count reset to 0.

Test Plan:
1. Status read, rs_sel=0, poll=0, lcd_data_in=8'h25 -> done at req+54; dado=25, busy_flag=0, timeout=0. lcd_en high exactly 25 cycles, rs=0, rw=1 and oe=0 from req+1 to req+53.
2. Data read, rs_sel=1, poll=1, lcd_data_in=8'hA5 -> single E pulse, lcd_rs=1, dado=A5, busy_flag=0.
3. Poll: lcd_data_in=8'h80 for 3 reads, then 8'h0C -> 4 E pulses, done at req+1+4*53, dado=0C, busy_flag=0, timeout=0.
4. Timeout with POLL_MAX=4, lcd_data_in stuck 8'h8F -> exactly 4 E pulses; done with timeout=1, dado=8F, busy_flag=1. Next accepted req clears timeout.
5. reset_reset_n low during EHIGH -> lcd_en, lcd_rw, lcd_rs go to 0, oe=1, ready=1 with no clock edge. After release, a fresh status read with 8'h25 matches scenario 1.
6. req pulsed during SETUP/ELOW -> ignored, single done. req held high -> done pulses every 55 cycles, each preceded by one ready=1 cycle.
